// File: rtl/uart_rx_frame.sv
// uart_rx_frame: recovers 8-bit UART frames (start, 8 data, optional parity, stop)
// from an oversampled serial line and emits one word per frame, good or bad.
//
// Ports:
//   clk, rst            system clock, asynchronous active-low reset
//   p_BaudSig_i         one-clk pulse at OVERSAMPLE x baud rate
//   Rx_i                asynchronous serial line, idle high
//   p_ParityEnable_i    parity bit present after the data bits
//   p_BigEnd_i          1: MSB received first, 0: LSB first
//   ParityMethod_i      0 even, 1 odd
//   data_o              received word, held until the next p_DataValid_o
//   p_DataValid_o       one-clk pulse per received word
//   p_ParityErr_o       parity mismatch for data_o (0 when parity disabled)
//   p_FrameErr_o        stop bit sampled low for data_o
//
// Optional build macro: RX_MAJORITY_VOTE_EN
//   Each bit is the 2-of-3 majority of rx_s at ticks centre-1, centre, centre+1,
//   resolved at centre+1. Undefined: single sample at the bit centre.

module uart_rx_frame #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p_BaudSig_i,
    input  logic       Rx_i,
    input  logic       p_ParityEnable_i,
    input  logic       p_BigEnd_i,
    input  logic       ParityMethod_i,
    output logic [7:0] data_o,
    output logic       p_DataValid_o,
    output logic       p_ParityErr_o,
    output logic       p_FrameErr_o
);

    localparam int unsigned CNT_W = $clog2(OVERSAMPLE + 2);
    localparam int unsigned HALF  = OVERSAMPLE / 2;
`ifdef RX_MAJORITY_VOTE_EN
    localparam int unsigned START_TICKS = HALF + 1;
`else
    localparam int unsigned START_TICKS = HALF;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rxState_t;

    rxState_t         state;
    logic             rxMeta;
    logic             rxS;
    logic             baudPrev;
    logic             baudTick_c;
    logic             bitVal_c;
    logic [CNT_W-1:0] tickCnt;
    logic [2:0]       bitCnt;
    logic [7:0]       shiftReg;
    logic             parEn;
    logic             bigEnd;
    logic             parOdd;
    logic             parErr;

    // Line synchroniser and baud-pulse edge detect (a stuck-high pulse gives one tick)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxMeta   <= 1'b1;
            rxS      <= 1'b1;
            baudPrev <= 1'b0;
        end else begin
            rxMeta   <= Rx_i;
            rxS      <= rxMeta;
            baudPrev <= p_BaudSig_i;
        end
    end

    assign baudTick_c = p_BaudSig_i & ~baudPrev;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] voteHist;

    // Last two tick samples; with the current sample they form the vote window
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            voteHist <= 2'b11;
        end else if (baudTick_c) begin
            voteHist <= {voteHist[0], rxS};
        end
    end

    assign bitVal_c = (voteHist[1] & voteHist[0]) | (voteHist[1] & rxS) | (voteHist[0] & rxS);
`else
    assign bitVal_c = rxS;
`endif

    // Frame FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            tickCnt       <= '0;
            bitCnt        <= '0;
            shiftReg      <= '0;
            parEn         <= 1'b0;
            bigEnd        <= 1'b0;
            parOdd        <= 1'b0;
            parErr        <= 1'b0;
            data_o        <= '0;
            p_DataValid_o <= 1'b0;
            p_ParityErr_o <= 1'b0;
            p_FrameErr_o  <= 1'b0;
        end else begin
            p_DataValid_o <= 1'b0;
            if (baudTick_c) begin
                case (state)
                    IDLE: begin
                        if (!rxS) begin
                            state   <= START;
                            tickCnt <= '0;
                            parEn   <= p_ParityEnable_i;
                            bigEnd  <= p_BigEnd_i;
                            parOdd  <= ParityMethod_i;
                        end
                    end
                    START: begin
                        if (tickCnt == CNT_W'(START_TICKS - 1)) begin
                            tickCnt <= '0;
                            bitCnt  <= '0;
                            state   <= bitVal_c ? IDLE : DATA;
                        end else begin
                            tickCnt <= tickCnt + CNT_W'(1);
                        end
                    end
                    DATA, PARITY, STOP: begin
                        if (tickCnt == CNT_W'(OVERSAMPLE - 1)) begin
                            tickCnt <= '0;
                            if (state == DATA) begin
                                shiftReg <= bigEnd ? {shiftReg[6:0], bitVal_c}
                                                   : {bitVal_c, shiftReg[7:1]};
                                bitCnt   <= bitCnt + 3'd1;
                                if (bitCnt == 3'd7) begin
                                    state <= parEn ? PARITY : STOP;
                                end
                            end else if (state == PARITY) begin
                                parErr <= ((^shiftReg) ^ bitVal_c) != parOdd;
                                state  <= STOP;
                            end else begin
                                // Word is published at the stop sample, valid or not
                                data_o        <= shiftReg;
                                p_DataValid_o <= 1'b1;
                                p_ParityErr_o <= parEn & parErr;
                                p_FrameErr_o  <= ~bitVal_c;
                                state         <= bitVal_c ? IDLE : BREAK;
                            end
                        end else begin
                            tickCnt <= tickCnt + CNT_W'(1);
                        end
                    end
                    BREAK: begin
                        if (rxS) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and randomized frames; expected words are
// queued when a frame is sent and checked by an independent output monitor.

module tb_uart_rx_frame;

    localparam int unsigned OS       = 16;
    localparam int unsigned BIT_CLKS = OS * 2;   // baud pulse every 2nd clk

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       baud   = 1'b0;
    logic       rx     = 1'b1;
    logic       parEn  = 1'b0;
    logic       bigEnd = 1'b0;
    logic       odd    = 1'b0;
    logic [7:0] dataO;
    logic       validO;
    logic       parErrO;
    logic       frameErrO;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t expQ[$];

    uart_rx_frame #(.OVERSAMPLE(OS)) dut (
        .clk              (clk),
        .rst              (rst),
        .p_BaudSig_i      (baud),
        .Rx_i             (rx),
        .p_ParityEnable_i (parEn),
        .p_BigEnd_i       (bigEnd),
        .ParityMethod_i   (odd),
        .data_o           (dataO),
        .p_DataValid_o    (validO),
        .p_ParityErr_o    (parErrO),
        .p_FrameErr_o     (frameErrO)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            baud = ~baud;
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every valid pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (validO === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=%h required=none", dataO);
            end else begin
                e = expQ.pop_front();
                check("data", dataO, e.d);
                check("parity_err", 8'(parErrO), 8'(e.pe));
                check("frame_err", 8'(frameErrO), 8'(e.fe));
            end
        end
    end

    task automatic sendBit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic idleBits(input int n);
        rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    // Drives one frame; abortAt >= 0 stops before that data bit (no word expected).
    // toggle flips all config inputs mid-frame; the receiver must ignore it.
    task automatic sendFrame(input logic [7:0] d, input logic pen, input logic be,
                             input logic od, input logic flip, input logic stopV,
                             input int abortAt, input logic toggle);
        logic pbit;
        exp_t e;
        parEn  = pen;
        bigEnd = be;
        odd    = od;
        pbit   = (^d) ^ od ^ flip;
        if (abortAt < 0) begin
            e.d  = d;
            e.pe = pen && (((^d) ^ pbit) != od);
            e.fe = !stopV;
            expQ.push_back(e);
        end
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == abortAt) return;
            if (toggle && i == 3) begin
                parEn  = !pen;
                bigEnd = !be;
                odd    = !od;
            end
            sendBit(be ? d[7 - i] : d[i]);
        end
        if (pen) sendBit(pbit);
        sendBit(stopV);
    endtask

    initial begin
        logic [7:0] rd;
        logic       rpen, rbe, rod, rflip, rstop, rtog;
        int         gap;

        repeat (3) @(negedge clk);
        check("reset_data", dataO, 8'h00);
        check("reset_valid", 8'(validO), 8'h00);
        check("reset_parity_err", 8'(parErrO), 8'h00);
        check("reset_frame_err", 8'(frameErrO), 8'h00);
        rst = 1'b1;
        idleBits(1);

        // 8N1 LSB first
        sendFrame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idleBits(1);
        // Even parity, wrong then correct parity bit
        sendFrame(8'h03, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
        idleBits(1);
        sendFrame(8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idleBits(1);
        // MSB first, then with config toggled mid-frame
        sendFrame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idleBits(1);
        sendFrame(8'h80, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b1);
        idleBits(1);

        // Glitch shorter than half a bit: no word
        rx = 1'b0;
        repeat (8) @(negedge clk);
        idleBits(2);

        // Line stuck low: exactly one zero word with frame error
        sendFrame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
        rx = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge clk);
        idleBits(2);
        sendFrame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idleBits(1);

        // Randomized frames with random gaps (including back-to-back)
        for (int n = 0; n < 24; n++) begin
            rd    = 8'($urandom);
            rpen  = 1'($urandom);
            rbe   = 1'($urandom);
            rod   = 1'($urandom);
            rflip = ($urandom % 3) == 0;
            rstop = ($urandom % 6) != 0;
            rtog  = 1'($urandom);
            sendFrame(rd, rpen, rbe, rod, rflip, rstop, -1, rtog);
            gap = int'($urandom % 3);
            if (!rstop && gap == 0) gap = 1;
            if (gap > 0) idleBits(gap);
        end
        idleBits(1);

        // Back-to-back pair, reset during the second frame's bit 4
        sendFrame(8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        sendFrame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4, 1'b0);
        rx  = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_data", dataO, 8'h00);
        check("midreset_valid", 8'(validO), 8'h00);
        check("midreset_frame_err", 8'(frameErrO), 8'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idleBits(8);

        // Recovers cleanly after reset
        sendFrame(8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
        idleBits(1);

        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL missing_words actual=%0d required=0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
